// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter. A load stores the period and starts the
// first bit; while run is high, bit_done pulses on the last cycle of every
// bit and the counter reloads from the stored period.
module uart_bit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             run,
  output logic             bit_done
);

  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] count_reg;

  assign bit_done = run && !load && (count_reg == WIDTH'(1));

  // Period capture on load, then count down and reload at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      period_reg <= load_val;
      count_reg  <= load_val;
    end else if (run) begin
      if (count_reg == WIDTH'(1)) begin
        count_reg <= period_reg;
      end else begin
        count_reg <= count_reg - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, STOP_BITS stop bits. The line idles high.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      txd,
  output logic                      busy,
  input  logic [PRESCALE_WIDTH-1:0] prescale
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  uart_tx_state_e            state_reg, state_next;
  logic                      txd_reg, txd_next;
  logic                      busy_reg, busy_next;
  logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
  logic [CNT_W-1:0]          bit_cnt_reg, bit_cnt_next;
  logic                      load;
  logic                      bit_done;
  logic [PRESCALE_WIDTH-1:0] prescale_eff;

  // A prescale of zero would never expire, so it runs as one cycle per bit.
  assign prescale_eff  = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign s_axis_tready = (state_reg == IDLE) && !rst;
  assign txd           = txd_reg;
  assign busy          = busy_reg;

  uart_bit_timer #(
    .WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(prescale_eff),
    .run     (state_reg != IDLE),
    .bit_done(bit_done)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_reg;

  // Parity of the accepted word, captured at the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= (^s_axis_tdata) ^ (PARITY_ODD != 0);
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // State, line and shifter registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      txd_reg     <= UART_IDLE_LEVEL;
      busy_reg    <= 1'b0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      txd_reg     <= txd_next;
      busy_reg    <= busy_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Next state and next registered line level, decided at each bit boundary.
  always_comb begin
    state_next   = state_reg;
    txd_next     = txd_reg;
    busy_next    = busy_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    load         = 1'b0;
    case (state_reg)
      IDLE: begin
        txd_next  = UART_IDLE_LEVEL;
        busy_next = 1'b0;
        if (s_axis_tvalid && s_axis_tready) begin
          load       = 1'b1;
          shift_next = s_axis_tdata;
          state_next = START;
          txd_next   = UART_START_LEVEL;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          txd_next     = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_reg == CNT_W'(DATA_WIDTH)) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            txd_next   = parity_reg;
`else
            state_next   = STOP;
            txd_next     = UART_IDLE_LEVEL;
            bit_cnt_next = CNT_W'(1);
`endif
          end else begin
            txd_next     = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next   = STOP;
          txd_next     = UART_IDLE_LEVEL;
          bit_cnt_next = CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (bit_cnt_reg == CNT_W'(STOP_BITS)) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
          txd_next = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = UART_IDLE_LEVEL;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Scoreboard bench for axis_uart_tx. dut0 uses one stop bit, dut1 two.
// Each queued entry is the hand-written txd sequence of one frame (one
// character per bit, start bit first) plus the cycles per bit.
`timescale 1ns/1ps
module tb_axis_uart_tx;

  localparam int DW = 8;
  localparam int PW = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tdata0 = '0, tdata1 = '0;
  logic          tvalid0 = 1'b0, tvalid1 = 1'b0;
  logic [PW-1:0] prescale0 = 16'd4, prescale1 = 16'd0;
  logic          tready0, tready1, txd0, txd1, busy0, busy1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  string bq0[$], bq1[$];
  int    pq0[$], pq1[$];
  bit    aq0[$], aq1[$];
  int    sq0[$];
  bit    mon_active[2];

  axis_uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0),
    .s_axis_tready(tready0), .txd(txd0), .busy(busy0), .prescale(prescale0)
  );

  axis_uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1),
    .s_axis_tready(tready1), .txd(txd1), .busy(busy1), .prescale(prescale1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_busy(input int idx);
    return (idx == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_txd(input int idx);
    return (idx == 0) ? txd0 : txd1;
  endfunction

  function automatic logic get_ready(input int idx);
    return (idx == 0) ? tready0 : tready1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int idx, input string bits, input int p, input bit ab);
    if (idx == 0) begin
      bq0.push_back(bits); pq0.push_back(p); aq0.push_back(ab);
    end else begin
      bq1.push_back(bits); pq1.push_back(p); aq1.push_back(ab);
    end
  endtask

  task automatic send(input int idx, input logic [DW-1:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (idx == 0) begin tdata0 = d; tvalid0 = 1'b1; end
    else begin tdata1 = d; tvalid1 = 1'b1; end
    for (int n = 0; n < 500; n++) begin
      if (get_ready(idx)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    if (!keep) begin
      if (idx == 0) tvalid0 = 1'b0;
      else tvalid1 = 1'b0;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout dut%0d: tready stayed 0 for word %0h", idx, d);
    end
  endtask

  // Monitor: on busy rising, pop one expected frame and follow it cycle by cycle.
  task automatic monitor(input int idx);
    string b;
    int    p, f;
    bit    ab, bad, aborted, got, eb;
    @(negedge clk);
    if (get_busy(idx) !== 1'b1) return;
    mon_active[idx] = 1'b1;
    if (idx == 0) sq0.push_back(cyc);
    got = 1'b0;
    if (idx == 0 && bq0.size() > 0) begin
      b = bq0.pop_front(); p = pq0.pop_front(); ab = aq0.pop_front(); got = 1'b1;
    end else if (idx == 1 && bq1.size() > 0) begin
      b = bq1.pop_front(); p = pq1.pop_front(); ab = aq1.pop_front(); got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL unexpected_frame dut%0d: busy=1 with no word queued at cycle %0d", idx, cyc);
      for (int n = 0; n < 5000 && get_busy(idx); n++) @(negedge clk);
      mon_active[idx] = 1'b0;
      return;
    end
    f = b.len() * p;
    bad = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < f; k++) begin
      if (k > 0) @(negedge clk);
      if (get_busy(idx) !== 1'b1) begin
        aborted = 1'b1;
        tests++;
        if (!ab) begin
          fails++;
          $display("FAIL busy_len dut%0d %s: busy fell after %0d cycles, required %0d", idx, b, k, f);
        end
        break;
      end
      eb = (b.getc(k / p) == 8'h31);
      if (get_txd(idx) !== eb && !bad) begin
        bad = 1'b1;
        $display("FAIL frame_bits dut%0d %s: frame cycle %0d txd=%b required %b", idx, b, k, get_txd(idx), eb);
      end
    end
    if (!aborted) begin
      tests++;
      if (bad) fails++;
      @(negedge clk);
      tests++;
      if (get_busy(idx) !== 1'b0 || get_txd(idx) !== 1'b1) begin
        fails++;
        $display("FAIL frame_end dut%0d %s: after %0d cycles busy=%b txd=%b, required busy=0 txd=1",
                 idx, b, f, get_busy(idx), get_txd(idx));
      end
      if (ab) begin
        tests++;
        fails++;
        $display("FAIL abort dut%0d %s: frame ran to completion, required abort by reset", idx, b);
      end
    end
    mon_active[idx] = 1'b0;
  endtask

  initial forever monitor(0);
  initial forever monitor(1);

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bq0.size() == 0 && bq1.size() == 0 && !mon_active[0] && !mon_active[1]
          && busy0 === 1'b0 && busy1 === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy0=%b busy1=%b queued=%0d/%0d", busy0, busy1, bq0.size(), bq1.size());
    end
  endtask

  initial begin
    int base;
    // Reset held with tvalid high: no handshake, idle line.
    rst = 1'b1; tvalid0 = 1'b1; tvalid1 = 1'b1; tdata0 = 8'hA5; tdata1 = 8'h81;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_c%0d_dut0 {tready,busy,txd}", i), {29'd0, tready0, busy0, txd0}, 32'h1);
      check($sformatf("reset_c%0d_dut1 {tready,busy,txd}", i), {29'd0, tready1, busy1, txd1}, 32'h1);
    end
    tvalid0 = 1'b0; tvalid1 = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_ready_dut0", {31'd0, tready0}, 32'h1);

    // 0xA5, prescale 4.
    prescale0 = 16'd4;
    expect_frame(0, (PB != 0) ? "01010010101" : "0101001011", 4, 1'b0);
    send(0, 8'hA5, 1'b0);
    wait_idle();

    // Back-to-back 0x00 then 0xFF with tvalid held, prescale 2.
    prescale0 = 16'd2;
    base = sq0.size();
    expect_frame(0, (PB != 0) ? "00000000001" : "0000000001", 2, 1'b0);
    expect_frame(0, (PB != 0) ? "01111111101" : "0111111111", 2, 1'b0);
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b0);
    wait_idle();
    check("b2b_start_gap", (sq0.size() >= base + 2) ? sq0[base+1] - sq0[base] : -1, 21 + 2 * PB);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; 11 bits of 3 cycles.
    prescale0 = 16'd3;
    expect_frame(0, "01110000011", 3, 1'b0);
    send(0, 8'h07, 1'b0);
    wait_idle();
`endif

    // Reset during data bit 3 of 0x55, then 0x3C.
    prescale0 = 16'd4;
    expect_frame(0, (PB != 0) ? "01010101001" : "0101010101", 4, 1'b1);
    send(0, 8'h55, 1'b0);
    repeat (17) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_line {busy,txd}", {30'd0, busy0, txd0}, 32'h1);
    rst = 1'b0;
    expect_frame(0, (PB != 0) ? "00011110001" : "0001111001", 4, 1'b0);
    send(0, 8'h3C, 1'b0);
    wait_idle();

    // prescale 0 on the two-stop-bit instance; prescale changed mid-frame.
    prescale1 = 16'd0;
    expect_frame(1, (PB != 0) ? "010000001011" : "01000000111", 1, 1'b0);
    send(1, 8'h81, 1'b0);
    prescale1 = 16'd5;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
